// File: rtl/up_sequencer.sv
// Nibble-CPU control unit: FETCH/EXEC phase machine, C/Z flags, strobe decode, retired count.
// Optional single-step parking state (WAIT) is enabled by defining UP_SINGLE_STEP_EN.
module up_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             step_mode,
  input  logic             step_btn,
  output logic             phase,
  output logic             incPC,
  output logic             loadPC,
  output logic             loadA,
  output logic             loadFlags,
  output logic [2:0]       opALU,
  output logic             cs,
  output logic             we,
  output logic             oeALU,
  output logic             oeIn,
  output logic             oeOprnd,
  output logic             loadOut,
  output logic             c_flag,
  output logic             z_flag,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b100;

  state_t           state_q;
  logic             c_q, z_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_jump, take;
  logic             step_edge;

`ifdef UP_SINGLE_STEP_EN
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], step_btn};
      prev_q <= sync_q[1];
    end
  end

  // Only consumed while parked, so edges seen in other states are dropped.
  assign step_edge = sync_q[1] & ~prev_q;
  assign halted    = (state_q == WAIT);
`else
  logic unused_step;
  assign unused_step = step_mode ^ step_btn;
  assign step_edge   = 1'b0;
  assign halted      = 1'b0;
`endif

  always_comb begin
    incPC     = 1'b0;
    loadPC    = 1'b0;
    loadA     = 1'b0;
    loadFlags = 1'b0;
    opALU     = OP_PASS;
    cs        = 1'b0;
    we        = 1'b0;
    oeALU     = 1'b0;
    oeIn      = 1'b0;
    oeOprnd   = 1'b0;
    loadOut   = 1'b0;
    is_jump   = 1'b0;
    take      = 1'b0;
    if (state_q == EXEC) begin
      case (instr)
        4'b0000: begin is_jump = 1'b1; take = c_q;  end
        4'b0001: begin is_jump = 1'b1; take = ~c_q; end
        4'b1000: begin is_jump = 1'b1; take = z_q;  end
        4'b1001: begin is_jump = 1'b1; take = ~z_q; end
        4'b1100: begin is_jump = 1'b1; take = 1'b1; end
        4'b0010: begin oeOprnd = 1'b1; opALU = OP_SUB;  loadFlags = 1'b1; end
        4'b0011: begin cs = 1'b1;      opALU = OP_SUB;  loadFlags = 1'b1; end
        4'b0100: begin oeOprnd = 1'b1; opALU = OP_PASS; loadA = 1'b1; end
        4'b0101: begin oeIn = 1'b1;    opALU = OP_PASS; loadA = 1'b1; end
        4'b0110: begin cs = 1'b1;      opALU = OP_PASS; loadA = 1'b1; end
        4'b0111: begin cs = 1'b1; we = 1'b1; oeALU = 1'b1; end
        4'b1010: begin oeOprnd = 1'b1; opALU = OP_ADD; loadA = 1'b1; loadFlags = 1'b1; end
        4'b1011: begin cs = 1'b1;      opALU = OP_ADD; loadA = 1'b1; loadFlags = 1'b1; end
        4'b1101: begin oeALU = 1'b1; loadOut = 1'b1; end
        4'b1110: begin oeOprnd = 1'b1; opALU = OP_NAND; loadA = 1'b1; end
        default: begin cs = 1'b1;      opALU = OP_NAND; loadA = 1'b1; end
      endcase
      loadPC = is_jump & take;
      incPC  = ~(is_jump & take);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        FETCH: state_q <= EXEC;
        EXEC: begin
          cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (loadFlags) begin
            c_q <= alu_c;
            z_q <= alu_z;
          end
`ifdef UP_SINGLE_STEP_EN
          state_q <= step_mode ? WAIT : FETCH;
`else
          state_q <= FETCH;
`endif
        end
`ifdef UP_SINGLE_STEP_EN
        WAIT: if (!step_mode || step_edge) state_q <= FETCH;
`endif
        default: state_q <= FETCH;
      endcase
    end
  end

  assign phase       = (state_q == EXEC);
  assign c_flag      = c_q;
  assign z_flag      = z_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_up_sequencer.sv
// Table-driven bench for up_sequencer with a strobe scoreboard and hand-written corner sequences.
module tb_up_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] instr = 4'b0100;
  logic       alu_c = 1'b0, alu_z = 1'b0, step_mode = 1'b0, step_btn = 1'b0;
  logic       phase, incPC, loadPC, loadA, loadFlags, cs, we, oeALU, oeIn, oeOprnd, loadOut;
  logic       c_flag, z_flag, halted;
  logic [2:0] opALU;
  logic [7:0] instr_count;

  up_sequencer #(.CNT_W(8)) dut (
    .clock(clock), .reset(reset), .instr(instr), .alu_c(alu_c), .alu_z(alu_z),
    .step_mode(step_mode), .step_btn(step_btn), .phase(phase), .incPC(incPC),
    .loadPC(loadPC), .loadA(loadA), .loadFlags(loadFlags), .opALU(opALU), .cs(cs),
    .we(we), .oeALU(oeALU), .oeIn(oeIn), .oeOprnd(oeOprnd), .loadOut(loadOut),
    .c_flag(c_flag), .z_flag(z_flag), .halted(halted), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // Strobe vector: {incPC,loadPC,loadA,loadFlags}_{opALU}_{cs,we,oeALU,oeIn,oeOprnd,loadOut}
  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic        c, z, ac, az;
    logic [12:0] s;
    logic        ec, ez;
  } vec_t;

  vec_t       tbl[22];
  vec_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_cnt = 8'd0;

  function automatic logic [12:0] strobes();
    return {incPC, loadPC, loadA, loadFlags, opALU, cs, we, oeALU, oeIn, oeOprnd, loadOut};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Must be entered in FETCH; returns after the EXEC edge.
  task automatic apply(input vec_t v);
    vec_t e;
    chk({v.nm, " fetch phase"}, 32'(phase), 32'd0);
    chk({v.nm, " fetch strobes"}, 32'(strobes()), 32'd0);
    instr = v.op;
    alu_c = v.ac;
    alu_z = v.az;
    sb.push_back(v);
    tick();
    e = sb.pop_front();
    chk({e.nm, " exec phase"}, 32'(phase), 32'd1);
    chk({e.nm, " strobes"}, 32'(strobes()), 32'(e.s));
    chk({e.nm, " bus onehot"}, 32'($countones({oeALU, oeIn, oeOprnd}) <= 1), 32'd1);
    chk({e.nm, " pc excl"}, 32'(loadPC & incPC), 32'd0);
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk({e.nm, " c_flag"}, 32'(c_flag), 32'(e.ec));
    chk({e.nm, " z_flag"}, 32'(z_flag), 32'(e.ez));
    chk({e.nm, " count"}, 32'(instr_count), 32'(exp_cnt));
  endtask

  task automatic set_flags(input logic c, input logic z);
    vec_t v;
    v = '{"CMPI set", 4'b0010, 1'b0, 1'b0, c, z, 13'b1001_001_000010, c, z};
    apply(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t lit00, v;
    lit00 = '{"LIT", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 13'b1010_000_000010, 1'b0, 1'b0};

    tbl[0]  = '{"JC c1",    4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 13'b0100_000_000000, 1'b1, 1'b0};
    tbl[1]  = '{"JNC c1",   4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 13'b1000_000_000000, 1'b1, 1'b0};
    tbl[2]  = '{"JZ z0",    4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 13'b1000_000_000000, 1'b1, 1'b0};
    tbl[3]  = '{"JNZ z0",   4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 13'b0100_000_000000, 1'b1, 1'b0};
    tbl[4]  = '{"JMP c1z0", 4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 13'b0100_000_000000, 1'b1, 1'b0};
    tbl[5]  = '{"JC c0",    4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 13'b1000_000_000000, 1'b0, 1'b1};
    tbl[6]  = '{"JNC c0",   4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 13'b0100_000_000000, 1'b0, 1'b1};
    tbl[7]  = '{"JZ z1",    4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 13'b0100_000_000000, 1'b0, 1'b1};
    tbl[8]  = '{"JNZ z1",   4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 13'b1000_000_000000, 1'b0, 1'b1};
    tbl[9]  = '{"JMP c0z1", 4'b1100, 1'b0, 1'b1, 1'b1, 1'b0, 13'b0100_000_000000, 1'b0, 1'b1};
    tbl[10] = '{"CMPI",     4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 13'b1001_001_000010, 1'b1, 1'b1};
    tbl[11] = '{"CMPM",     4'b0011, 1'b1, 1'b1, 1'b0, 1'b1, 13'b1001_001_100000, 1'b0, 1'b1};
    tbl[12] = '{"LIT",      4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 13'b1010_000_000010, 1'b1, 1'b0};
    tbl[13] = '{"IN",       4'b0101, 1'b0, 1'b1, 1'b1, 1'b0, 13'b1010_000_000100, 1'b0, 1'b1};
    tbl[14] = '{"LD",       4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 13'b1010_000_100000, 1'b1, 1'b1};
    tbl[15] = '{"ST",       4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 13'b1000_000_111000, 1'b0, 1'b0};
    tbl[16] = '{"ADDI",     4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 13'b1011_010_000010, 1'b1, 1'b0};
    tbl[17] = '{"ADDM",     4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 13'b1011_010_100000, 1'b0, 1'b0};
    tbl[18] = '{"OUT",      4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 13'b1000_000_001001, 1'b1, 1'b0};
    tbl[19] = '{"NANDI",    4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 13'b1010_100_000010, 1'b0, 1'b1};
    tbl[20] = '{"NANDM",    4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 13'b1010_100_100000, 1'b1, 1'b0};
    tbl[21] = '{"JMP c1z1", 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 13'b0100_000_000000, 1'b1, 1'b1};

    tick();
    tick();
    chk("reset phase", 32'(phase), 32'd0);
    chk("reset c_flag", 32'(c_flag), 32'd0);
    chk("reset z_flag", 32'(z_flag), 32'd0);
    chk("reset count", 32'(instr_count), 32'd0);
    chk("reset halted", 32'(halted), 32'd0);
    chk("reset strobes", 32'(strobes()), 32'd0);
    reset = 1'b0;

    apply(lit00);
    apply(lit00);
    chk("LIT x2 count", 32'(instr_count), 32'd2);

    v = '{"ADDI seq", 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 13'b1011_010_000010, 1'b1, 1'b0};
    apply(v);
    v = '{"NANDI seq", 4'b1110, 1'b1, 1'b0, 1'b0, 1'b1, 13'b1010_100_000010, 1'b1, 1'b0};
    apply(v);

    for (int i = 0; i < 22; i++) begin
      set_flags(tbl[i].c, tbl[i].z);
      apply(tbl[i]);
    end

    // Reset landing on the EXEC edge of a CMPI must suppress flag load and count.
    instr = 4'b0010;
    alu_c = 1'b1;
    alu_z = 1'b1;
    tick();
    chk("mid reset exec phase", 32'(phase), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid reset phase", 32'(phase), 32'd0);
    chk("mid reset z_flag", 32'(z_flag), 32'd0);
    chk("mid reset c_flag", 32'(c_flag), 32'd0);
    chk("mid reset count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    exp_cnt = 8'd0;

    instr = 4'b0100;
    for (int i = 0; i < 255; i++) begin
      tick();
      tick();
      exp_cnt = exp_cnt + 8'd1;
    end
    chk("count 255", 32'(instr_count), 32'd255);
    tick();
    tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("count wrap", 32'(instr_count), 32'd0);

`ifdef UP_SINGLE_STEP_EN
    step_mode = 1'b1;
    apply(lit00);
    chk("wait halted", 32'(halted), 32'd1);
    chk("wait phase", 32'(phase), 32'd0);
    chk("wait strobes", 32'(strobes()), 32'd0);
    repeat (3) tick();
    chk("wait hold count", 32'(instr_count), 32'(exp_cnt));
    chk("wait hold halted", 32'(halted), 32'd1);
    step_btn = 1'b1;
    repeat (5) tick();
    step_btn = 1'b0;
    repeat (10) tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("step one count", 32'(instr_count), 32'(exp_cnt));
    chk("step reparked", 32'(halted), 32'd1);
    step_mode = 1'b0;
    tick();
    chk("resume halted", 32'(halted), 32'd0);
    chk("resume phase", 32'(phase), 32'd0);
    apply(lit00);
    chk("free run halted", 32'(halted), 32'd0);
`else
    step_mode = 1'b1;
    step_btn = 1'b1;
    apply(lit00);
    chk("no step halted", 32'(halted), 32'd0);
    apply(lit00);
    chk("no step halted 2", 32'(halted), 32'd0);
    step_mode = 1'b0;
    step_btn = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
